// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the elastic pipeline stage chain.
//   WB_REGWRITE / WB_MEMTOREG : bit positions of the write-back control field
//   DEPTH_MAX                 : largest supported number of stages
//   OCC_W                     : width of the occupancy count
//   popcount()                : counts set bits of a DEPTH_MAX-wide valid vector
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int unsigned WB_REGWRITE = 0;
   localparam int unsigned WB_MEMTOREG = 1;
   localparam int unsigned DEPTH_MAX   = 8;
   localparam int unsigned OCC_W       = 4;

   function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH_MAX-1:0] v);
      logic [OCC_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH_MAX; i++) begin
         cnt = cnt + OCC_W'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain_if
// Upstream and downstream handshake/payload bundle of the stage chain.
// Signal suffixes are seen from the chain: _i driven into it, _o driven by it.
//   in_valid_i/in_ready_o              : upstream handshake
//   ctrl_i/data_i/addr_i               : upstream entry
//   out_valid_o/out_ready_i            : downstream handshake
//   ctrl_o/data_o/addr_o               : last-stage entry
// Modports: slave = the chain, master = whoever drives and consumes it.
// -----------------------------------------------------------------------------
interface pipe_stage_chain_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 2,
   parameter int unsigned ADDR_W = 5
);

   logic              in_valid_i;
   logic              in_ready_o;
   logic [CTRL_W-1:0] ctrl_i;
   logic [DATA_W-1:0] data_i;
   logic [ADDR_W-1:0] addr_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [CTRL_W-1:0] ctrl_o;
   logic [DATA_W-1:0] data_o;
   logic [ADDR_W-1:0] addr_o;

   modport master (
      output in_valid_i, ctrl_i, data_i, addr_i, out_ready_i,
      input  in_ready_o, out_valid_o, ctrl_o, data_o, addr_o
   );

   modport slave (
      input  in_valid_i, ctrl_i, data_i, addr_i, out_ready_i,
      output in_ready_o, out_valid_o, ctrl_o, data_o, addr_o
   );

endinterface

// File: rtl/pipe_stage_cell.sv
// -----------------------------------------------------------------------------
// pipe_stage_cell
// One register stage of the chain: valid bit plus ctrl/data/addr payload.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : invalidate this stage at the next edge
//   load_i         : take valid_i/ctrl_i/data_i/addr_i at the next edge
//   valid_i..addr_i: entry offered by the upstream stage (or chain input)
//   valid_o..addr_o: current stage contents
//   valid_nxt_o    : value valid_o will take at the next edge (ignores reset)
// -----------------------------------------------------------------------------
module pipe_stage_cell #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 2,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              valid_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              valid_nxt_o
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_addr;

   logic              w_valid_nxt;
   logic [CTRL_W-1:0] w_ctrl_nxt;
   logic              w_take_payload;

   // Bubbles carry an all-zero control field so no write enable leaks downstream.
   always_comb begin
      w_valid_nxt = r_valid;
      w_ctrl_nxt  = r_ctrl;
      if (flush_i) begin
         w_valid_nxt = 1'b0;
         w_ctrl_nxt  = '0;
      end else if (load_i) begin
         w_valid_nxt = valid_i;
         w_ctrl_nxt  = valid_i ? ctrl_i : '0;
      end
   end

   assign w_take_payload = load_i && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_data  <= '0;
         r_addr  <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         r_ctrl  <= w_ctrl_nxt;
         if (w_take_payload) begin
            r_data <= data_i;
            r_addr <= addr_i;
         end
      end
   end

   assign valid_o     = r_valid;
   assign ctrl_o      = r_ctrl;
   assign data_o      = r_data;
   assign addr_o      = r_addr;
   assign valid_nxt_o = w_valid_nxt;

endmodule

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
// DEPTH elastic register stages with valid/ready handshake, bubble collapsing,
// global stall, flush and synchronous reset. DEPTH must lie in 1..DEPTH_MAX.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, overrides stall and flush
//   stall_i     : freeze every stage, refuse input, count no output transfer
//   flush_i     : invalidate every stage and drop the offered entry
//   bus         : handshake/payload bundle (slave side), see pipe_stage_chain_if
//   occupancy_o : registered number of valid stages
// -----------------------------------------------------------------------------
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   input  logic                   flush_i,
   pipe_stage_chain_if.slave      bus,
   output logic [OCC_W-1:0]       occupancy_o
);

   logic [DEPTH-1:0]     w_valid;
   logic [DEPTH-1:0]     w_valid_nxt;
   logic [CTRL_W-1:0]    w_ctrl [DEPTH];
   logic [DATA_W-1:0]    w_data [DEPTH];
   logic [ADDR_W-1:0]    w_addr [DEPTH];
   logic [DEPTH:0]       w_rdy;
   logic                 w_advance;
   logic [DEPTH_MAX-1:0] w_valid_pad;
   logic [OCC_W-1:0]     r_occ;

   assign w_advance = !stall_i && !flush_i;

   // A stage can take a new entry if it is empty or its own entry moves on,
   // which lets an empty stage fill while everything below it is blocked.
   always_comb begin
      w_rdy        = '0;
      w_rdy[DEPTH] = bus.out_ready_i;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_rdy[k] = !w_valid[k] || w_rdy[k+1];
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic              w_src_valid;
      logic [CTRL_W-1:0] w_src_ctrl;
      logic [DATA_W-1:0] w_src_data;
      logic [ADDR_W-1:0] w_src_addr;

      if (k == 0) begin : g_head
         assign w_src_valid = bus.in_valid_i;
         assign w_src_ctrl  = bus.ctrl_i;
         assign w_src_data  = bus.data_i;
         assign w_src_addr  = bus.addr_i;
      end else begin : g_tail
         assign w_src_valid = w_valid[k-1];
         assign w_src_ctrl  = w_ctrl[k-1];
         assign w_src_data  = w_data[k-1];
         assign w_src_addr  = w_addr[k-1];
      end

      pipe_stage_cell #(
         .DATA_W (DATA_W),
         .CTRL_W (CTRL_W),
         .ADDR_W (ADDR_W)
      ) u_cell (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .flush_i     (flush_i),
         .load_i      (w_advance && w_rdy[k]),
         .valid_i     (w_src_valid),
         .ctrl_i      (w_src_ctrl),
         .data_i      (w_src_data),
         .addr_i      (w_src_addr),
         .valid_o     (w_valid[k]),
         .ctrl_o      (w_ctrl[k]),
         .data_o      (w_data[k]),
         .addr_o      (w_addr[k]),
         .valid_nxt_o (w_valid_nxt[k])
      );
   end

   assign bus.in_ready_o  = w_rdy[0] && w_advance;
   assign bus.out_valid_o = w_valid[DEPTH-1];
   assign bus.ctrl_o      = w_ctrl[DEPTH-1] & {CTRL_W{w_valid[DEPTH-1]}};
   assign bus.data_o      = w_data[DEPTH-1];
   assign bus.addr_o      = w_addr[DEPTH-1];

   // Count the next-state valid bits so occupancy moves on the same edge.
   always_comb begin
      w_valid_pad            = '0;
      w_valid_pad[DEPTH-1:0] = w_valid_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_occ <= '0;
      end else begin
         r_occ <= popcount(w_valid_pad);
      end
   end

   assign occupancy_o = r_occ;

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID … MEM/WB).
- Implements DEPTH elastic register stages carrying a CTRL_W control field and a DATA_W payload.
- Adds the following behaviour:
  - valid/ready handshake with bubble collapsing;
  - global stall;
  - flush;
  - synchronous reset;
  - control-field zeroing for bubbles, so a bubble never asserts RegWrite or MemWrite downstream.

Parameters:
- DATA_W, 64, payload width in bits (e.g. MemData + RegData).
- CTRL_W, 2, control field width (bit0 RegWrite, bit1 MemtoReg for the WB use).
- ADDR_W, 5, register-address sideband width.
- DEPTH, 1, number of register stages; legal range 1..8.

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  freezes every stage; no load, no drain.
- flush_i  in  1  invalidates every stage at the next edge.
- in_valid_i  in  1  upstream holds a valid entry.
- in_ready_o  out  1  chain accepts the entry this cycle.
- ctrl_i  in  CTRL_W  control field.
- data_i  in  DATA_W  payload.
- addr_i  in  ADDR_W  destination register address.
- out_valid_o  out  1  last stage holds a valid entry.
- out_ready_i  in  1  downstream consumes this cycle.
- ctrl_o  out  CTRL_W  last-stage control, forced 0 when out_valid_o=0.
- data_o  out  DATA_W  last-stage payload.
- addr_o  out  ADDR_W  last-stage address.
- occupancy_o  out  4  count of valid stages, 0..DEPTH.

Behaviour:
- Reset (rst_i=1 at posedge):
  - all valid bits, ctrl, data and addr registers go to 0;
  - out_valid_o=0, ctrl_o=0, data_o=0, addr_o=0, occupancy_o=0.
  - Reset overrides stall_i and flush_i.
- Stage k (0..DEPTH-1) has valid[k] and payload regs. Ready chain is combinational:
  - rdy[DEPTH] = out_ready_i;
  - rdy[k] = !valid[k] | rdy[k+1];
  - in_ready_o = rdy[0] & !stall_i & !flush_i.
- Advance: when !stall_i & !flush_i & rdy[k]:
  - stage k loads from stage k-1, or from the inputs for k=0;
  - valid[k] <= valid[k-1], or in_valid_i for k=0;
  - if the loaded entry is invalid, ctrl[k] <= 0; data and addr may be written with don't-care.
- Bubble collapsing: an empty stage accepts from upstream even while downstream is blocked.
- Latency and throughput:
  - with no backpressure, an entry accepted at edge N appears on the outputs after edge N+DEPTH-1 (DEPTH cycles of residence);
  - throughput is 1 entry per cycle.
- Handshake rules:
  - transfer out happens when out_valid_o & out_ready_i & !stall_i;
  - an output entry is held stable while out_valid_o=1 and it is not transferred;
  - in_valid_i is not required to hold when in_ready_o=0, but an entry is only taken when in_ready_o=1.
- Stall (stall_i=1, flush_i=0):
  - all registers hold;
  - in_ready_o=0;
  - out_valid_o still reflects the held entry, but no transfer is counted even if out_ready_i=1.
- Flush (flush_i=1):
  - all valid[k] <= 0 and all ctrl[k] <= 0 at the next edge;
  - the input entry that cycle is dropped;
  - flush wins over stall.
- ctrl_o = ctrl[DEPTH-1] & {CTRL_W{valid[DEPTH-1]}}. It is never nonzero with out_valid_o=0.
- occupancy_o:
  - registered popcount of the valid bits, updated at the same edge as the valid bits;
  - 0 after reset or flush.
- Full: all valid and out_ready_i=0 gives in_ready_o=0.
- Simultaneous in/out when full: if out_ready_i=1, the whole chain shifts and in_ready_o=1 in the same cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - WB control bit indices (WB_REGWRITE=0, WB_MEMTOREG=1);
  - the DEPTH_MAX=8 constant;
  - OCC_W=4.
- One sub-module, pipe_stage_cell:
  - one stage's valid bit, ctrl/data/addr regs and its local load/zero logic;
  - instantiated DEPTH times by a generate loop.
- The top level holds the ready chain, flush/stall gating and occupancy.

Test Plan:
- Reset with DEPTH=3: after rst_i held 2 cycles, all outputs are 0 and in_ready_o=1 even with in_valid_i=1 during reset.
- Streaming with DEPTH=3, out_ready_i=1:
  - send ctrl=2'b01, data=0xA5, addr=7 at edge 0, then entries 8 and 9 back-to-back;
  - out_valid_o rises after edge 2, and three consecutive outputs appear in order with no gaps.
- Backpressure and collapse with DEPTH=3:
  - with out_ready_i=0, feed 3 entries; occupancy_o=3 and in_ready_o=0;
  - raise out_ready_i for 1 cycle; in_ready_o=1 the same cycle, and a 4th entry is accepted with occupancy staying at 3.
- Flush with the chain full: flush_i for 1 cycle gives out_valid_o=0, ctrl_o=0 and occupancy_o=0 next cycle; the entry offered that cycle never appears.
- Stall: with stall_i=1 for 4 cycles and out_ready_i=1, outputs hold value and no entry is lost or duplicated after release.
- Bubble ctrl with DEPTH=2: send valid, gap, valid with ctrl=2'b11; during the gap cycle out_valid_o=0 and ctrl_o=2'b00.
